demux4_stream: RTL and testbench

//   Registered 1-to-4 stream demultiplexer: the receive/fan-out counterpart of our 4:1 mux.

---
 rtl/demux4_stream_pkg.sv | 14 +
 rtl/demux4_stream_if.sv | 29 ++
 rtl/demux4_stream_slot.sv | 53 +++++
 rtl/demux4_stream.sv | 57 +++++
 tb/tb_demux4_stream.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux4_stream_pkg.sv
// Shared constants and select decode for the 1-to-4 stream demultiplexer.
package dsd_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // One-hot channel masks, indexed by select value
  localparam logic [NUM_CH-1:0] CH_MASK [NUM_CH] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  function automatic logic [NUM_CH-1:0] ch_decode(input logic [SEL_W-1:0] sel);
    return CH_MASK[sel];
  endfunction

endpackage

// File: rtl/demux4_stream_if.sv
// Stream bundle between one shared producer and four consumers.
// master = producer/consumer side, slave = demultiplexer side.
interface demux4_stream_if
  import dsd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [SEL_W-1:0]           in_sel;
  logic [DATA_W-1:0]          in_data;
  logic [NUM_CH-1:0]          out_valid;
  logic [NUM_CH-1:0]          out_ready;
  logic [NUM_CH*DATA_W-1:0]   out_data;
  logic [NUM_CH*CNT_W-1:0]    out_cnt;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );

endinterface

// File: rtl/demux4_stream_slot.sv
// One output channel: single-entry holding register plus delivered-beat counter.
module demux_slot #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_drain;

  assign w_drain = r_valid & i_ready;

  // Holding register: load wins over drain so a full slot refills without a bubble;
  // flush only invalidates, the stale data stays in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Delivered-beat counter: every drain counts, flush cycle included; wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer: select decode, in_ready mux, four channel slots.
module demux4_stream
  import dsd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  demux4_stream_if.slave    bus
);

  logic [NUM_CH-1:0] w_valid;
  logic [DATA_W-1:0] w_data [NUM_CH];
  logic [CNT_W-1:0]  w_cnt  [NUM_CH];
  logic [NUM_CH-1:0] w_load;
  logic              w_in_ready;
  logic              w_acc;

  // Ready follows the selected slot: empty, or draining this very cycle
  assign w_in_ready = rst_n & ~flush &
                      (~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel]);
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_load     = w_acc ? ch_decode(bus.in_sel) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_load  (w_load[g]),
      .i_ready (bus.out_ready[g]),
      .i_data  (bus.in_data),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  // Pack per-channel data and counters onto the flat output buses
  always_comb begin
    bus.out_data = '0;
    bus.out_cnt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.out_data[i*DATA_W +: DATA_W] = w_data[i];
      bus.out_cnt[i*CNT_W +: CNT_W]    = w_cnt[i];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: scoreboard monitor plus directed checks.
module tb_demux4_stream;
  import dsd_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush4;

  int n_tests = 0;
  int n_fail  = 0;

  demux4_stream_if #(.DATA_W(8), .CNT_W(8)) bus ();
  demux4_stream_if #(.DATA_W(8), .CNT_W(4)) bus4 ();

  demux4_stream #(.DATA_W(8), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  demux4_stream #(.DATA_W(8), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush4),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded)
  task automatic send(input logic [1:0] s, input logic [7:0] d);
    int n;
    bus.in_valid = 1'b1;
    bus.in_sel   = s;
    bus.in_data  = d;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: expected beats per channel, expected counters
  logic [7:0] exp_q [4][$];
  logic [7:0] exp_cnt [4];
  logic       prev_hold;
  logic [1:0] prev_sel;
  logic [7:0] prev_data;

  initial begin
    prev_hold = 1'b0;
    prev_sel  = '0;
    prev_data = '0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
  end

  always @(negedge clk) begin
    logic [3:0] mv;
    logic       exp_rdy;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        exp_cnt[i] = '0;
      end
      prev_hold = 1'b0;
      chk("mon_rst_valid", 32'(bus.out_valid), 32'(0));
      chk("mon_rst_cnt", bus.out_cnt, 32'(0));
    end else begin
      for (int i = 0; i < 4; i++) mv[i] = (exp_q[i].size() != 0);
      chk("mon_valid", 32'(bus.out_valid), 32'(mv));
      for (int i = 0; i < 4; i++) begin
        if (mv[i]) chk($sformatf("mon_data%0d", i), 32'(bus.out_data[i*8 +: 8]), 32'(exp_q[i][0]));
        chk($sformatf("mon_cnt%0d", i), 32'(bus.out_cnt[i*8 +: 8]), 32'(exp_cnt[i]));
      end
      exp_rdy = !flush && (!mv[bus.in_sel] || bus.out_ready[bus.in_sel]);
      chk("mon_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (prev_hold) begin
        chk("stable_valid", 32'(bus.in_valid), 32'(1));
        chk("stable_sel", 32'(bus.in_sel), 32'(prev_sel));
        chk("stable_data", 32'(bus.in_data), 32'(prev_data));
      end
      prev_hold = bus.in_valid && !exp_rdy && !flush;
      prev_sel  = bus.in_sel;
      prev_data = bus.in_data;
      for (int i = 0; i < 4; i++) begin
        if (mv[i] && bus.out_ready[i]) begin
          void'(exp_q[i].pop_front());
          exp_cnt[i] = exp_cnt[i] + 8'd1;
        end
      end
      if (flush) begin
        for (int i = 0; i < 4; i++) exp_q[i].delete();
      end else if (bus.in_valid && exp_rdy) begin
        exp_q[bus.in_sel].push_back(bus.in_data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    flush          = 1'b0;
    flush4         = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_sel     = '0;
    bus.in_data    = '0;
    bus.out_ready  = '0;
    bus4.in_valid  = 1'b0;
    bus4.in_sel    = '0;
    bus4.in_data   = '0;
    bus4.out_ready = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("por_valid", 32'(bus.out_valid), 32'(0));
    chk("por_cnt", bus.out_cnt, 32'(0));
    chk("por_data", bus.out_data, 32'(0));
    chk("por_in_ready", 32'(bus.in_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Route each select to its channel
    bus.out_ready = 4'hF;
    for (int i = 0; i < 4; i++) send(2'(i), 8'(8'hA0 + i));
    repeat (3) tick();
    @(negedge clk);
    chk("route_cnt", bus.out_cnt, 32'h01010101);
    tick();

    // Backpressure on ch2, then no-bubble refill
    bus.out_ready = 4'b1011;
    send(2'd2, 8'h55);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 8'h66;
    @(negedge clk);
    chk("bp_in_ready_lo", 32'(bus.in_ready), 32'(0));
    chk("bp_hold_data", 32'(bus.out_data[23:16]), 32'h55);
    tick();
    bus.out_ready[2] = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_hi", 32'(bus.in_ready), 32'(1));
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid2", 32'(bus.out_valid[2]), 32'(1));
    chk("bp_data2", 32'(bus.out_data[23:16]), 32'h66);
    tick();

    // Independence: ch1 stalled and full, ch3 still accepts
    bus.out_ready = 4'b0101;
    send(2'd1, 8'h11);
    send(2'd3, 8'h33);
    @(negedge clk);
    chk("indep_valid", 32'(bus.out_valid), 32'b1010);
    tick();
    bus.out_ready = 4'hF;
    repeat (2) tick();

    // Flush with ch0 and ch2 full, ch0 draining in the flush cycle
    bus.out_ready = 4'b0000;
    send(2'd0, 8'hC0);
    send(2'd2, 8'hC2);
    @(negedge clk);
    chk("fl_pre_valid", 32'(bus.out_valid), 32'b0101);
    tick();
    flush         = 1'b1;
    bus.out_ready = 4'b0001;
    @(negedge clk);
    chk("fl_in_ready", 32'(bus.in_ready), 32'(0));
    tick();
    flush         = 1'b0;
    bus.out_ready = 4'b0000;
    @(negedge clk);
    chk("fl_valid", 32'(bus.out_valid), 32'(0));
    chk("fl_cnt0", 32'(bus.out_cnt[7:0]), 32'd2);
    chk("fl_cnt1", 32'(bus.out_cnt[15:8]), 32'd2);
    chk("fl_cnt2", 32'(bus.out_cnt[23:16]), 32'd3);
    chk("fl_cnt3", 32'(bus.out_cnt[31:24]), 32'd2);
    chk("fl_data_kept", 32'(bus.out_data[7:0]), 32'hC0);
    tick();

    // Asynchronous reset mid-stream with ch0 and ch2 full
    send(2'd0, 8'hD0);
    send(2'd2, 8'hD2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
    chk("mid_rst_cnt", bus.out_cnt, 32'(0));
    chk("mid_rst_data", bus.out_data, 32'(0));
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 4'hF;
    send(2'd1, 8'hE1);
    repeat (2) tick();
    @(negedge clk);
    chk("post_rst_cnt", bus.out_cnt, 32'h00000100);
    tick();

    // Counter wrap on a 4-bit counter instance: 17 beats to ch1
    bus4.in_sel   = 2'd1;
    bus4.in_data  = 8'h5A;
    bus4.in_valid = 1'b1;
    repeat (17) tick();
    bus4.in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_zero", 32'(bus4.out_cnt[7:4]), 32'd0);
    @(negedge clk);
    chk("wrap_one", 32'(bus4.out_cnt[7:4]), 32'd1);
    chk("wrap_others", 32'({bus4.out_cnt[15:8], bus4.out_cnt[3:0]}), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
